get_bit: RTL and testbench

//  Bitstream unpacker; the read-side counterpart of set_bit for the ProRes decode/verify path.

---
 rtl/bitstream_pkg.sv | 30 +++
 rtl/get_bit_extract.sv | 20 ++
 rtl/get_bit.sv | 96 +++++++++
 tb/tb_get_bit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bitstream_pkg.sv
// Shared definitions for the set_bit/get_bit bitstream pair: default sizes,
// port widths and the MSB-first byte-count encoding of a packed data word.
package bitstream_pkg;

  localparam int unsigned BUF_BITS_DEF = 128;
  localparam int unsigned MAX_READ_DEF = 64;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned BCNT_W    = 4;
  localparam int unsigned SIZE_W    = 7;
  localparam int unsigned LEVEL_W   = 8;
  localparam int unsigned TOTAL_W   = 32;
  localparam int unsigned BYTES_MAX = 8;

  typedef logic [BCNT_W-1:0] bcnt_t;

  // Number of valid bits carried by a word with n bytes; counts above 8 saturate.
  function automatic logic [LEVEL_W-1:0] bcnt_bits(input bcnt_t n);
    if (n > bcnt_t'(BYTES_MAX)) begin
      return LEVEL_W'(BYTES_MAX * 8);
    end
    return LEVEL_W'({n, 3'b000});
  endfunction

  // Mask selecting the first n bytes of a word; byte 0 sits in [63:56].
  function automatic logic [DATA_W-1:0] bcnt_mask(input bcnt_t n);
    return ~({DATA_W{1'b1}} >> bcnt_bits(n));
  endfunction

endpackage

// File: rtl/get_bit_extract.sv
// Field extractor: right-justifies the top i_size bits of the buffer head.
module get_bit_extract
  import bitstream_pkg::*;
#(
  parameter int unsigned MAX_READ = MAX_READ_DEF
) (
  input  logic [MAX_READ-1:0] i_top,
  input  logic [SIZE_W-1:0]   i_size,
  output logic [MAX_READ-1:0] o_field
);

  logic [SIZE_W-1:0] w_shift;

  // A zero size shifts everything out, giving an all-zero field.
  always_comb begin
    w_shift = SIZE_W'(MAX_READ) - i_size;
    o_field = i_top >> w_shift;
  end

endmodule

// File: rtl/get_bit.sv
// Bitstream unpacker: byte-packed MSB-first words go into a bit buffer and
// fields of 1..64 bits come out right-justified, with byte alignment support.
module get_bit
  import bitstream_pkg::*;
#(
  parameter int unsigned BUF_BITS = BUF_BITS_DEF,
  parameter int unsigned MAX_READ = MAX_READ_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [BCNT_W-1:0]    in_byte_count,
  input  logic                 rd_enable,
  input  logic [SIZE_W-1:0]    rd_size_of_bit,
  input  logic                 rd_align,
  output logic                 rd_ready,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_val,
  output logic [TOTAL_W-1:0]   total_bit_count,
  output logic [LEVEL_W-1:0]   level
);

  // Buffer MSB is the oldest bit; bits below r_level are kept zero.
  logic [BUF_BITS-1:0] r_buf;
  logic [LEVEL_W-1:0]  r_level;
  logic [TOTAL_W-1:0]  r_total;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_val;

  logic                w_push;
  logic                w_read;
  logic [LEVEL_W-1:0]  w_consumed;
  logic [LEVEL_W-1:0]  w_lvl_after;
  logic [BUF_BITS-1:0] w_push_bits;
  logic [BUF_BITS-1:0] w_buf_d;
  logic [LEVEL_W-1:0]  w_level_d;
  logic [MAX_READ-1:0] w_field;

  assign in_ready = (r_level <= LEVEL_W'(BUF_BITS - DATA_W));
  assign rd_ready = (r_level >= {1'b0, rd_size_of_bit});

  get_bit_extract #(
    .MAX_READ (MAX_READ)
  ) u_extract (
    .i_top   (r_buf[BUF_BITS-1 -: MAX_READ]),
    .i_size  (rd_size_of_bit),
    .o_field (w_field)
  );

  // Work out what is consumed this cycle, then append the new bytes after what remains.
  always_comb begin
    w_push     = in_valid && in_ready;
    w_read     = rd_enable && rd_ready && !rd_align;
    w_consumed = '0;
    if (rd_align) begin
      w_consumed = {5'b00000, r_level[2:0]};
    end else if (w_read) begin
      w_consumed = {1'b0, rd_size_of_bit};
    end
    w_lvl_after = r_level - w_consumed;
    w_push_bits = '0;
    if (w_push) begin
      w_push_bits = {in_data & bcnt_mask(in_byte_count), {(BUF_BITS - DATA_W){1'b0}}}
                    >> w_lvl_after;
    end
    w_buf_d   = (r_buf << w_consumed) | w_push_bits;
    w_level_d = w_lvl_after + (w_push ? bcnt_bits(in_byte_count) : '0);
  end

  // Buffer, level, consumed-bit counter and registered read result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_buf       <= '0;
      r_level     <= '0;
      r_total     <= '0;
      r_out_valid <= 1'b0;
      r_out_val   <= '0;
    end else begin
      r_buf       <= w_buf_d;
      r_level     <= w_level_d;
      r_total     <= r_total + {{(TOTAL_W - LEVEL_W){1'b0}}, w_consumed};
      r_out_valid <= w_read;
      if (w_read) begin
        r_out_val <= DATA_W'(w_field);
      end
    end
  end

  assign out_valid       = r_out_valid;
  assign out_val         = r_out_val;
  assign total_bit_count = r_total;
  assign level           = r_level;

endmodule

// File: tb/tb_get_bit.sv
// Self-checking bench for get_bit: directed table, hand sequences and random traffic
// against a bit-queue reference model.
module tb_get_bit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [3:0]  in_byte_count;
  logic        rd_enable;
  logic [6:0]  rd_size_of_bit;
  logic        rd_align;
  logic        rd_ready;
  logic        out_valid;
  logic [63:0] out_val;
  logic [31:0] total_bit_count;
  logic [7:0]  level;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered bits oldest-first, plus expected registered outputs.
  bit          mq[$];
  logic [31:0] m_total;
  logic [63:0] m_val;
  logic        m_valid;

  always #5 clock = ~clock;

  get_bit dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_byte_count   (in_byte_count),
    .rd_enable       (rd_enable),
    .rd_size_of_bit  (rd_size_of_bit),
    .rd_align        (rd_align),
    .rd_ready        (rd_ready),
    .out_valid       (out_valid),
    .out_val         (out_val),
    .total_bit_count (total_bit_count),
    .level           (level)
  );

  // Field width 0 or above 64 is never legal on a real read request.
  always @(posedge clock) begin
    if (reset_n && rd_enable && !rd_align && (rd_size_of_bit == 0 || rd_size_of_bit > 64))
      $error("illegal rd_size_of_bit %0d", rd_size_of_bit);
  end

  typedef struct {
    logic        iv;
    logic [3:0]  n;
    logic [63:0] d;
    logic        re;
    logic [6:0]  sz;
    logic        al;
    logic        x_inr;
    logic        x_rdr;
    logic        x_ov;
    logic [63:0] x_val;
    logic [7:0]  x_lvl;
    logic [31:0] x_tot;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [3:0] n, input logic [63:0] d,
                       input logic re, input logic [6:0] sz, input logic al);
    in_valid       = iv;
    in_byte_count  = n;
    in_data        = d;
    rd_enable      = re;
    rd_size_of_bit = sz;
    rd_align       = al;
  endtask

  task automatic model_reset();
    mq.delete();
    m_total = 0;
    m_val   = 0;
    m_valid = 0;
  endtask

  // One cycle against the model: pre-edge handshake checks, then post-edge state checks.
  task automatic step(input logic iv, input logic [3:0] n, input logic [63:0] d,
                      input logic re, input logic [6:0] sz, input logic al);
    int          lvl;
    bit          acc;
    bit          rr;
    logic [63:0] v;
    drive(iv, n, d, re, sz, al);
    #1;
    lvl = mq.size();
    acc = iv && (lvl <= 64);
    rr  = (lvl >= int'(sz));
    chk("in_ready", 64'(in_ready), 64'(lvl <= 64));
    chk("rd_ready", 64'(rd_ready), 64'(rr));
    m_valid = 0;
    if (al) begin
      for (int i = 0; i < lvl % 8; i++) void'(mq.pop_front());
      m_total += 32'(lvl % 8);
    end else if (re && rr) begin
      v = 0;
      for (int i = 0; i < int'(sz); i++) v = {v[62:0], mq.pop_front()};
      m_val   = v;
      m_valid = 1;
      m_total += 32'(sz);
    end
    if (acc) begin
      for (int i = 0; i < 8 * int'(n); i++) mq.push_back(d[63-i]);
    end
    @(posedge clock);
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_val", out_val, m_val);
    chk("level", 64'(level), 64'(mq.size()));
    chk("total", 64'(total_bit_count), 64'(m_total));
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_val", out_val, 64'd0);
    chk("rst_total", 64'(total_bit_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    model_reset();
    drive(0, 0, 0, 0, 7'd1, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 7'd1, 0);
    model_reset();

    //          iv n  data                    re sz     al inr rdr ov val                    lvl  tot
    tbl[0] = '{1, 1, 64'hA5FF_FFFF_FFFF_FFFF, 0, 7'd3,  0, 1,  0,  0, 64'h0,                 8,   0};
    tbl[1] = '{0, 0, 64'h0,                   1, 7'd3,  0, 1,  1,  1, 64'h5,                 5,   3};
    tbl[2] = '{0, 0, 64'h0,                   1, 7'd5,  0, 1,  1,  1, 64'h5,                 0,   8};
    tbl[3] = '{1, 8, 64'h0123_4567_89AB_CDEF, 0, 7'd1,  0, 1,  0,  0, 64'h5,                 64,  8};
    tbl[4] = '{0, 0, 64'h0,                   1, 7'd64, 0, 1,  1,  1, 64'h0123_4567_89AB_CDEF, 0, 72};
    tbl[5] = '{0, 0, 64'h0,                   1, 7'd1,  0, 1,  0,  0, 64'h0123_4567_89AB_CDEF, 0, 72};
    tbl[6] = '{1, 2, 64'hF03C_DEAD_BEEF_1234, 0, 7'd4,  0, 1,  0,  0, 64'h0123_4567_89AB_CDEF, 16, 72};
    tbl[7] = '{0, 0, 64'h0,                   1, 7'd4,  0, 1,  1,  1, 64'hF,                 12,  76};
    tbl[8] = '{0, 0, 64'h0,                   1, 7'd4,  1, 1,  1,  0, 64'hF,                 8,   80};
    tbl[9] = '{0, 0, 64'h0,                   1, 7'd8,  0, 1,  1,  1, 64'h3C,                0,   88};

    // Reset values while held in reset, then release.
    #12;
    chk("init_level", 64'(level), 64'd0);
    chk("init_out_valid", 64'(out_valid), 64'd0);
    chk("init_total", 64'(total_bit_count), 64'd0);
    chk("init_in_ready", 64'(in_ready), 64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Directed table: push/read, full-word read, empty retry, align with read ignored.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].iv, tbl[i].n, tbl[i].d, tbl[i].re, tbl[i].sz, tbl[i].al);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].x_inr));
      chk($sformatf("tbl%0d_rd_ready", i), 64'(rd_ready), 64'(tbl[i].x_rdr));
      @(posedge clock);
      #1;
      chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].x_ov));
      chk($sformatf("tbl%0d_out_val", i), out_val, tbl[i].x_val);
      chk($sformatf("tbl%0d_level", i), 64'(level), 64'(tbl[i].x_lvl));
      chk($sformatf("tbl%0d_total", i), 64'(total_bit_count), 64'(tbl[i].x_tot));
    end

    // Full buffer: third word held off until a 64-bit read frees space.
    do_reset();
    step(1, 8, 64'h1111_2222_3333_4444, 0, 7'd1, 0);
    step(1, 8, 64'h5555_6666_7777_8888, 0, 7'd1, 0);
    chk("full_level", 64'(level), 64'd128);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    step(1, 8, 64'h9999_AAAA_BBBB_CCCC, 0, 7'd1, 0);
    step(1, 8, 64'h9999_AAAA_BBBB_CCCC, 1, 7'd64, 0);
    chk("full_first_word", out_val, 64'h1111_2222_3333_4444);
    chk("full_in_ready_after", 64'(in_ready), 64'd1);
    step(1, 8, 64'h9999_AAAA_BBBB_CCCC, 0, 7'd1, 0);
    chk("full_level_refill", 64'(level), 64'd128);
    step(0, 0, 0, 1, 7'd64, 0);
    chk("full_second_word", out_val, 64'h5555_6666_7777_8888);
    step(0, 0, 0, 1, 7'd64, 0);
    chk("full_third_word", out_val, 64'h9999_AAAA_BBBB_CCCC);

    // Simultaneous push and read at level 16; align takes priority over a read.
    do_reset();
    step(1, 2, 64'hBEEF_0000_0000_0000, 0, 7'd1, 0);
    step(1, 2, 64'h1234_FFFF_FFFF_FFFF, 1, 7'd16, 0);
    chk("sim_old_bits", out_val, 64'hBEEF);
    chk("sim_level", 64'(level), 64'd16);
    step(0, 0, 0, 1, 7'd8, 1);
    chk("sim_align_noop_valid", 64'(out_valid), 64'd0);
    step(0, 0, 0, 1, 7'd3, 0);
    step(0, 0, 0, 1, 7'd8, 1);
    chk("sim_align_level", 64'(level), 64'd8);
    chk("sim_align_valid", 64'(out_valid), 64'd0);
    step(0, 0, 0, 1, 7'd8, 0);
    chk("sim_tail", out_val, 64'h34);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic        iv;
      logic [3:0]  n;
      logic        re;
      logic        al;
      logic [6:0]  sz;
      iv = ($urandom_range(0, 99) < 55);
      n  = 4'($urandom_range(0, 8));
      re = ($urandom_range(0, 99) < 60);
      al = ($urandom_range(0, 99) < 8);
      sz = 7'($urandom_range(1, 64));
      step(iv, n, {$urandom, $urandom}, re, sz, al);
    end

    // Reset in the middle of a stream discards everything buffered.
    step(1, 8, 64'hDEAD_BEEF_CAFE_F00D, 0, 7'd1, 0);
    do_reset();
    step(1, 1, 64'h8100_0000_0000_0000, 0, 7'd1, 0);
    step(0, 0, 0, 1, 7'd8, 0);
    chk("post_reset_byte", out_val, 64'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
